// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 5-stage pipeline control slice
package pipe_pkg;
  localparam int REG_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mem_state_e;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage status in, pipeline control and perf counters out
interface pipe_ctrl_if #(parameter int CNT_W = 16);
  import pipe_pkg::*;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             mem_req_r;
  logic             mem_req_w;
  logic             exe_br_taken;
  logic             freeze;
  logic             pc_hold;
  logic             id_bubble;
  logic             flush;
  logic             sram_en;
  logic             sram_we;
  logic             mem_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r,
           mem_dest, mem_wb_en, mem_req_r, mem_req_w, exe_br_taken,
    input  freeze, pc_hold, id_bubble, flush, sram_en, sram_we, mem_done, stall_cnt, freeze_cnt
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r,
           mem_dest, mem_wb_en, mem_req_r, mem_req_w, exe_br_taken,
    output freeze, pc_hold, id_bubble, flush, sram_en, sram_we, mem_done, stall_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: RAW compare of ID sources against in-flight EXE/MEM destinations
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int FWD_EN = 0
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);
  logic raw_exe, raw_mem;
  assign raw_exe = exe_wb_en & (id_src1 == exe_dest | id_two_src & id_src2 == exe_dest);
  assign raw_mem = mem_wb_en & (id_src1 == mem_dest | id_two_src & id_src2 == mem_dest);
  // with forwarding only a load still in EXE cannot be bypassed in time
  assign hazard = id_valid & (FWD_EN != 0 ? raw_exe & exe_mem_r : raw_exe | raw_mem);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard stalls, multi-cycle SRAM access freeze, branch flush sequencing
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT = 4,
  parameter int FWD_EN   = 0,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);
  localparam int WCNT_W = $clog2(MEM_WAIT > 3 ? MEM_WAIT - 2 : 2);
  mem_state_e        state, state_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  logic [CNT_W-1:0]  stall_cnt, freeze_cnt;
  logic              req, hazard, frz, done, br;
  assign req = bus.mem_req_r | bus.mem_req_w;
  assign br  = bus.exe_br_taken;
  hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .id_valid  (bus.id_valid),
    .id_src1   (bus.id_src1),
    .id_src2   (bus.id_src2),
    .id_two_src(bus.id_two_src),
    .exe_dest  (bus.exe_dest),
    .exe_wb_en (bus.exe_wb_en),
    .exe_mem_r (bus.exe_mem_r),
    .mem_dest  (bus.mem_dest),
    .mem_wb_en (bus.mem_wb_en),
    .hazard    (hazard)
  );
  // the request cycle in IDLE is the first wait cycle, so BUSY covers MEM_WAIT-2 more
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    frz      = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        frz  = req & (MEM_WAIT > 1);
        done = req & (MEM_WAIT == 1);
        if (frz) begin
          state_nx = MEM_WAIT == 2 ? DONE : BUSY;
          wcnt_nx  = WCNT_W'(MEM_WAIT - 3);
        end
      end
      BUSY: begin
        frz      = 1'b1;
        state_nx = wcnt == '0 ? DONE : BUSY;
        wcnt_nx  = wcnt == '0 ? wcnt : wcnt - 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      state      <= state_nx;
      wcnt       <= wcnt_nx;
      stall_cnt  <= stall_cnt + CNT_W'(bus.pc_hold & ~&stall_cnt);
      freeze_cnt <= freeze_cnt + CNT_W'(bus.freeze & ~&freeze_cnt);
    end
  end
  // combinational outputs are gated so everything reads 0 while reset is held
  assign bus.freeze     = rst & frz;
  assign bus.flush      = rst & br & ~frz;
  assign bus.pc_hold    = rst & hazard & ~frz & ~br;
  assign bus.id_bubble  = bus.flush | bus.pc_hold;
  assign bus.sram_en    = rst & (req | state != IDLE);
  assign bus.sram_we    = bus.sram_en & bus.mem_req_w;
  assign bus.mem_done   = rst & done;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.freeze_cnt = freeze_cnt;
endmodule
